if_id_skid: RTL and testbench
=============================

# if_id_skid

Parametrised IF/ID pipeline stage: the fetch-to-decode register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush. It sits between the instruction fetch unit and the decoder. When empty or flushed it presents the NOP instruction and address 0 to decode. Full throughput (one instruction per cycle) is sustained under back-pressure without a combinational ready path from decode to fetch.

## Interface
Parameters:
- INST_W, 32, instruction width
- ADDR_W, 32, instruction address width
- NOP, 32'h0000_0013, instruction presented when no valid entry (addi x0,x0,0); width INST_W
- CNT_W, 8, width of flush-drop counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept; depends only on registered state
- inst_i  in  INST_W  fetched instruction
- inst_addr_i  in  ADDR_W  fetched instruction address
- flush_i  in  1  synchronous flush (branch/jump redirect)
- out_valid  out  1  inst_o/inst_addr_o hold a real instruction
- out_ready  in  1  decode accepts this cycle
- inst_o  out  INST_W  instruction to decode
- inst_addr_o  out  ADDR_W  address to decode
- flush_cnt  out  CNT_W  saturating count of valid entries discarded by flush

## Operation
- Storage: main entry (drives outputs) and skid entry, each with a valid bit. State is encoded as EMPTY (none valid), ONE (main only), or FULL (main and skid).
- accept = in_valid & in_ready; take = out_valid & out_ready.
- in_ready = (state != FULL).
- out_valid = (state != EMPTY).
- inst_o/inst_addr_o = main entry when out_valid, else NOP/0. Outputs come from registers, with no combinational path from inst_i.
- Transitions when flush_i = 0:
  - EMPTY: accept → ONE, main ← input. Otherwise stay.
  - ONE, accept & take → ONE, main ← input.
  - ONE, accept & !take → FULL, skid ← input.
  - ONE, !accept & take → EMPTY.
  - ONE, neither → hold.
  - FULL: take → ONE, main ← skid. Otherwise hold. No accept is possible in FULL.
- Flush has priority over everything:
  - Next state is EMPTY. Any input accepted in the flush cycle is discarded.
  - in_ready stays as computed from the current state.
  - A take in the flush cycle still counts as consumed by decode.
- flush_cnt on flush: adds the number of valid entries discarded (main + skid, 0..2), excluding main if taken that same cycle. Saturates at all-ones, never wraps.
- Order is strictly FIFO: main is always older than skid.

## Timing
- Reset (async assert, sync release):
  - state EMPTY, out_valid 0, in_ready 1
  - inst_o = NOP, inst_addr_o = 0
  - flush_cnt 0
- Latency: accept in cycle N gives out_valid with that data in cycle N+1.
- Throughput: 1/cycle while out_ready = 1.
- Back-pressure: with out_ready low, at most 2 accepts occur before in_ready falls. in_ready deasserts the cycle after the second accept.
- Flush in cycle N: cycle N+1 has out_valid 0, inst_o NOP, in_ready 1, and flush_cnt updated.
- Reset mid-operation clears all entries immediately, with no partial drain. flush_cnt returns to 0.
- No X propagation: the skid entry is never visible on the outputs unless promoted to main.

## Test plan
- Reset: hold rst_n low with random inputs → out_valid 0, inst_o 0x00000013, inst_addr_o 0, in_ready 1, flush_cnt 0. Release, then send inst 0x00500093 @ 0x0 → out_valid and data appear the next cycle.
- Streaming: out_ready = 1, send 8 instructions at addresses 0x0..0x1C on consecutive cycles → 8 outputs on consecutive cycles, in order, 1-cycle latency, in_ready never drops.
- Back-pressure: out_ready = 0, offer A@0x10, B@0x14, C@0x18 → A and B accepted, in_ready 0 after B, C held. Raise out_ready → outputs A, B, C in order with no gap and no duplicate.
- Flush FULL: buffer holds A and B, out_ready = 0, flush_i pulse with in_valid (D@0x40) → next cycle out_valid 0, inst_o NOP, flush_cnt = 2, D never output. Then D2@0x40 is accepted normally.
- Flush with take: state ONE, out_ready = 1, flush_i = 1 → flush_cnt unchanged. Repeated 2-entry flushes from flush_cnt = 254 → 255, then stays 255.
- Reset mid-stream: assert rst_n low while FULL → same cycle (async) out_valid 0, in_ready 1, inst_o NOP, flush_cnt 0.

Source files
------------

// File: rtl/if_id_skid.sv
// ---------------------------------------------------------------------------
// if_id_skid
//   IF/ID pipeline register with a valid/ready handshake, a 2-entry skid
//   buffer and a synchronous flush. It sits between instruction fetch and
//   decode.
//
//   in_ready is derived only from registered state, so there is no
//   combinational path from out_ready to in_ready. Full throughput is still
//   sustained under back-pressure because the skid entry catches the one
//   instruction that fetch may send while decode stalls.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    fetch-side handshake
//   inst_i, inst_addr_i    fetched instruction and its address
//   flush_i                synchronous redirect; drops every held entry
//   out_valid / out_ready  decode-side handshake
//   inst_o, inst_addr_o    main entry, or NOP/0 when nothing is valid
//   flush_cnt              saturating count of valid entries dropped by flush
// ---------------------------------------------------------------------------
module if_id_skid #(
    parameter int                INST_W = 32,
    parameter int                ADDR_W = 32,
    parameter logic [INST_W-1:0] NOP    = INST_W'(32'h0000_0013),
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              flush_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [CNT_W-1:0]  flush_cnt
);

    // EMPTY: nothing held. ONE: main only. FULL: main and skid.
    // The main entry is always older than the skid entry.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [INST_W-1:0]  main_inst_q, main_inst_d;
    logic [ADDR_W-1:0]  main_addr_q, main_addr_d;
    logic [INST_W-1:0]  skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0]  skid_addr_q, skid_addr_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               accept;
    logic               take;
    logic [1:0]         drop_n;
    logic [CNT_W:0]     cnt_sum;

    // Handshake signals depend only on the registered state.
    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    // Only the main entry ever reaches decode. The skid entry becomes
    // visible only after it has been promoted into main.
    assign inst_o      = out_valid ? main_inst_q : NOP;
    assign inst_addr_o = out_valid ? main_addr_q : '0;
    assign flush_cnt   = flush_cnt_q;

    always_comb begin
        state_d     = state_q;
        main_inst_d = main_inst_q;
        main_addr_d = main_addr_q;
        skid_inst_d = skid_inst_q;
        skid_addr_d = skid_addr_q;
        flush_cnt_d = flush_cnt_q;
        drop_n      = 2'd0;
        cnt_sum     = '0;

        if (flush_i) begin
            // A main entry that decode takes in the flush cycle counts as
            // consumed, not dropped. Any input accepted this cycle is lost
            // on purpose, because the redirect makes it stale.
            drop_n  = 2'((state_q != S_EMPTY) && !take) + 2'(state_q == S_FULL);
            cnt_sum = {1'b0, flush_cnt_q} + (CNT_W+1)'(drop_n);
            flush_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d     = S_ONE;
                        main_inst_d = inst_i;
                        main_addr_d = inst_addr_i;
                    end
                end
                S_ONE: begin
                    if (accept && take) begin
                        main_inst_d = inst_i;
                        main_addr_d = inst_addr_i;
                    end else if (accept) begin
                        state_d     = S_FULL;
                        skid_inst_d = inst_i;
                        skid_addr_d = inst_addr_i;
                    end else if (take) begin
                        state_d     = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // No accept is possible here because in_ready is low.
                    if (take) begin
                        state_d     = S_ONE;
                        main_inst_d = skid_inst_q;
                        main_addr_d = skid_addr_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Data registers are also reset, so that no X can reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            main_inst_q <= '0;
            main_addr_q <= '0;
            skid_inst_q <= '0;
            skid_addr_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_inst_q <= main_inst_d;
            main_addr_q <= main_addr_d;
            skid_inst_q <= skid_inst_d;
            skid_addr_q <= skid_addr_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid.sv
// ---------------------------------------------------------------------------
// tb_if_id_skid
//   Directed testbench for if_id_skid, using the default parameters.
//   Inputs are driven 1 ns after each rising edge, and outputs are checked
//   at that same point.
// ---------------------------------------------------------------------------
module tb_if_id_skid;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 8;
    localparam logic [INST_W-1:0] NOP_I = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] inst_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              flush_i;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic [CNT_W-1:0]  flush_cnt;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    if_id_skid #(.INST_W(INST_W), .ADDR_W(ADDR_W), .NOP(NOP_I), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a);
        in_valid    = v;
        inst_i      = i;
        inst_addr_i = a;
    endtask

    // Empty the stage by flushing. This also updates the expected count.
    task automatic go_empty();
        logic [8:0] s;
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b0;
        flush_i   = 1'b1;
        s = {1'b0, exp_cnt} + 9'(out_valid) + 9'(!in_ready);
        exp_cnt = s[8] ? 8'hFF : s[7:0];
        step();
        flush_i = 1'b0;
    endtask

    task automatic fill_full(input logic [31:0] ia, input logic [31:0] ib);
        out_ready = 1'b0;
        drive(1'b1, ia, 32'h10); step();
        drive(1'b1, ib, 32'h14); step();
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1; flush_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, $urandom, $urandom);
            out_ready = 1'($urandom);
            flush_i   = 1'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b0 || inst_o !== NOP_I || inst_addr_o !== '0 ||
                in_ready !== 1'b1 || flush_cnt !== '0) begin
                errors++;
                $display("FAIL reset_state: ov=%b inst=%h addr=%h ir=%b cnt=%0d want 0/00000013/0/1/0",
                         out_valid, inst_o, inst_addr_o, in_ready, flush_cnt);
            end
        end
        drive(1'b0, 0, 0); flush_i = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        step();
        drive(1'b1, 32'h0050_0093, 32'h0);
        step();
        drive(1'b0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || inst_o !== 32'h0050_0093 || inst_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL first_latency: ov=%b inst=%h addr=%h want 1/00500093/0",
                     out_valid, inst_o, inst_addr_o);
        end
        go_empty();
        checks++;
        if (flush_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL reset_flush_cnt: got %0d want %0d", flush_cnt, exp_cnt);
        end
    endtask

    task automatic test_streaming();
        logic ir_drop = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (in_ready !== 1'b1) ir_drop = 1'b1;
            drive(1'b1, 32'hA000_0000 + k, 32'(k * 4));
            step();
            checks++;
            if (out_valid !== 1'b1 || inst_o !== 32'hA000_0000 + k || inst_addr_o !== 32'(k * 4)) begin
                errors++;
                $display("FAIL stream_%0d: ov=%b inst=%h addr=%h want 1/%h/%h",
                         k, out_valid, inst_o, inst_addr_o, 32'hA000_0000 + k, k * 4);
            end
        end
        drive(1'b0, 0, 0);
        checks++;
        if (ir_drop !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready: dropped=%b in_ready=%b want 0/1", ir_drop, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || inst_o !== NOP_I) begin
            errors++;
            $display("FAIL stream_drain: ov=%b inst=%h want 0/00000013", out_valid, inst_o);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 32'h10); step();
        drive(1'b1, 32'hBBBB_0002, 32'h14); step();
        checks++;
        if (in_ready !== 1'b0 || inst_o !== 32'hAAAA_0001 || inst_addr_o !== 32'h10) begin
            errors++;
            $display("FAIL bp_full: ir=%b inst=%h addr=%h want 0/aaaa0001/10", in_ready, inst_o, inst_addr_o);
        end
        drive(1'b1, 32'hCCCC_0003, 32'h18); step();
        checks++;
        if (in_ready !== 1'b0 || inst_o !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL bp_hold: ir=%b inst=%h want 0/aaaa0001", in_ready, inst_o);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || inst_o !== 32'hBBBB_0002 || inst_addr_o !== 32'h14 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_out_b: ov=%b inst=%h addr=%h ir=%b want 1/bbbb0002/14/1",
                     out_valid, inst_o, inst_addr_o, in_ready);
        end
        step();
        drive(1'b0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || inst_o !== 32'hCCCC_0003 || inst_addr_o !== 32'h18) begin
            errors++;
            $display("FAIL bp_out_c: ov=%b inst=%h addr=%h want 1/cccc0003/18", out_valid, inst_o, inst_addr_o);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: ov=%b inst=%h want 0", out_valid, inst_o);
        end
    endtask

    task automatic test_flush_full();
        fill_full(32'hAAAA_0001, 32'hBBBB_0002);
        out_ready = 1'b0;
        flush_i = 1'b1;
        drive(1'b1, 32'hDDDD_0004, 32'h40);
        exp_cnt = exp_cnt + 8'd2;
        step();
        flush_i = 1'b0;
        drive(1'b0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || inst_o !== NOP_I || inst_addr_o !== '0 ||
            in_ready !== 1'b1 || flush_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL flush_full: ov=%b inst=%h addr=%h ir=%b cnt=%0d want 0/00000013/0/1/%0d",
                     out_valid, inst_o, inst_addr_o, in_ready, flush_cnt, exp_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_d: ov=%b inst=%h want 0", out_valid, inst_o);
        end
        drive(1'b1, 32'hDDDD_0005, 32'h40);
        step();
        drive(1'b0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || inst_o !== 32'hDDDD_0005 || inst_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL flush_then_d2: ov=%b inst=%h addr=%h want 1/dddd0005/40", out_valid, inst_o, inst_addr_o);
        end
    endtask

    task automatic test_flush_take();
        // The stage is in ONE, holding D2.
        out_ready = 1'b1;
        flush_i   = 1'b1;
        step();
        flush_i = 1'b0;
        checks++;
        if (flush_cnt !== exp_cnt || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_take_one: cnt=%0d ov=%b want %0d/0", flush_cnt, out_valid, exp_cnt);
        end
        // In FULL with take, only the skid entry is dropped.
        fill_full(32'h1111_0001, 32'h2222_0002);
        out_ready = 1'b1;
        flush_i   = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        step();
        flush_i = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (flush_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL flush_take_full: cnt=%0d want %0d", flush_cnt, exp_cnt);
        end
        // Flushing in ONE without a take drops one entry, which makes the count even.
        if (exp_cnt[0]) begin
            drive(1'b1, 32'h3333_0003, 32'h20); step(); drive(1'b0, 0, 0);
            flush_i = 1'b1;
            exp_cnt = exp_cnt + 8'd1;
            step();
            flush_i = 1'b0;
        end
        while (exp_cnt < 8'd254) begin
            fill_full(32'h4444_0004, 32'h5555_0005);
            flush_i = 1'b1;
            exp_cnt = exp_cnt + 8'd2;
            step();
            flush_i = 1'b0;
        end
        checks++;
        if (flush_cnt !== 8'd254) begin
            errors++;
            $display("FAIL flush_cnt_254: got %0d want 254", flush_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            fill_full(32'h6666_0006, 32'h7777_0007);
            flush_i = 1'b1;
            step();
            flush_i = 1'b0;
            checks++;
            if (flush_cnt !== 8'd255) begin
                errors++;
                $display("FAIL flush_cnt_sat_%0d: got %0d want 255", k, flush_cnt);
            end
        end
        exp_cnt = 8'd255;
    endtask

    task automatic test_reset_mid();
        fill_full(32'h8888_0008, 32'h9999_0009);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_prefill: ir=%b ov=%b want 0/1", in_ready, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || inst_o !== NOP_I ||
            inst_addr_o !== '0 || flush_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: ov=%b ir=%b inst=%h addr=%h cnt=%0d want 0/1/00000013/0/0",
                     out_valid, in_ready, inst_o, inst_addr_o, flush_cnt);
        end
        exp_cnt = '0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_release: ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 0, 0);
        flush_i = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_full();
        test_flush_take();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
